// File: rtl/dcache_stall_ctrl.sv
// Data-cache miss stall sequencer.
// Freezes the whole pipeline while a MEM-stage access misses, merging the miss stall with the
// hazard unit's bubble and flush requests.
// Flushes raised during a miss are held back and released on the first unstalled cycle.
// The block also keeps miss statistics and raises a sticky watchdog error for stuck refills.
module dcache_stall_ctrl #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,         // asynchronous, active-low
  input  logic             i_miss,
  input  logic             i_mem_req,
  input  logic [4:0]       i_bubble_hz,     // {F,D,E,M,W}
  input  logic [4:0]       i_flush_hz,      // {F,D,E,M,W}
  input  logic             i_clr_stats,
  output logic [4:0]       o_bubble_out,
  output logic [4:0]       o_flush_out,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_miss_events,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic             o_timeout_err
);

  localparam int unsigned LEN_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    IDLE,
    STALL
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_cur_len;
  logic [4:0]       r_pend_flush;
  logic [CNT_W-1:0] r_miss_events;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_timeout_err;

  logic w_stall;
  logic w_new_miss;
  logic w_timeout_hit;

  // A miss on a stale flag (no MEM access) must not freeze anything.
  assign w_stall       = i_mem_req & i_miss;
  assign w_new_miss    = w_stall && (r_state == IDLE);
  // The current stall length reaches the limit on this edge.
  assign w_timeout_hit = w_stall && (r_state == STALL) && (r_cur_len == LEN_MAX - LEN_W'(1));

  // Bubbles dominate during a stall: no frozen stage is cleared underneath its request.
  assign o_stall        = w_stall;
  assign o_bubble_out   = i_bubble_hz | {5{w_stall}};
  assign o_flush_out    = w_stall ? 5'b00000 : (i_flush_hz | r_pend_flush);
  assign o_miss_events  = r_miss_events;
  assign o_stall_cycles = r_stall_cycles;
  assign o_timeout_err  = r_timeout_err;

  // Stall FSM, stall-length tracking, and the deferred-flush accumulator.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cur_len    <= '0;
      r_pend_flush <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stall) begin
            r_state   <= STALL;
            r_cur_len <= LEN_W'(1);
          end else begin
            r_cur_len <= '0;
          end
        end
        STALL: begin
          if (w_stall) begin
            if (r_cur_len != LEN_MAX) r_cur_len <= r_cur_len + LEN_W'(1);
          end else begin
            r_state   <= IDLE;
            r_cur_len <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cur_len <= '0;
        end
      endcase
      // Anything pending was already driven on o_flush_out in an unstalled cycle.
      r_pend_flush <= w_stall ? (r_pend_flush | i_flush_hz) : 5'b00000;
    end
  end

  // Saturating statistics and the sticky watchdog; a clear wins over same-cycle updates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_miss_events  <= '0;
      r_stall_cycles <= '0;
      r_timeout_err  <= 1'b0;
    end else if (i_clr_stats) begin
      r_miss_events  <= '0;
      r_stall_cycles <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      if (w_new_miss && !(&r_miss_events)) r_miss_events <= r_miss_events + CNT_W'(1);
      if (w_stall && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Randomised and directed bench for dcache_stall_ctrl.
// A behavioural reference model tracks the stall episodes, deferred flushes and statistics.
module tb_dcache_stall_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             miss;
  logic             mem_req;
  logic [4:0]       bubble_hz;
  logic [4:0]       flush_hz;
  logic             clr_stats;
  logic [4:0]       bubble_out;
  logic [4:0]       flush_out;
  logic             stall;
  logic [CNT_W-1:0] miss_events;
  logic [CNT_W-1:0] stall_cycles;
  logic             timeout_err;

  int n_cmp;
  int n_err;

  // Reference model state
  bit       m_in_stall;
  int       m_len;
  bit [4:0] m_pend;
  int       m_events;
  int       m_cycles;
  bit       m_tout;

  dcache_stall_ctrl #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_miss        (miss),
    .i_mem_req     (mem_req),
    .i_bubble_hz   (bubble_hz),
    .i_flush_hz    (flush_hz),
    .i_clr_stats   (clr_stats),
    .o_bubble_out  (bubble_out),
    .o_flush_out   (flush_out),
    .o_stall       (stall),
    .o_miss_events (miss_events),
    .o_stall_cycles(stall_cycles),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_stall = 0;
    m_len      = 0;
    m_pend     = '0;
    m_events   = 0;
    m_cycles   = 0;
    m_tout     = 0;
  endtask

  // One clock cycle: drive, compare at the falling edge, then advance the model at the edge.
  task automatic step(input bit req, input bit ms, input bit [4:0] bhz, input bit [4:0] fhz,
                      input bit clr);
    bit       s;
    int       old_len;
    bit [4:0] exp_fl;
    mem_req   = req;
    miss      = ms;
    bubble_hz = bhz;
    flush_hz  = fhz;
    clr_stats = clr;
    s         = req && ms;
    exp_fl    = s ? 5'b00000 : (fhz | m_pend);
    #4;
    check("stall", 32'(stall), 32'(s));
    check("bubble", 32'(bubble_out), 32'(s ? 5'b11111 : bhz));
    check("flush", 32'(flush_out), 32'(exp_fl));
    check("events", 32'(miss_events), 32'(m_events));
    check("cycles", 32'(stall_cycles), 32'(m_cycles));
    check("tout", 32'(timeout_err), 32'(m_tout));
    @(posedge clk);
    old_len = m_len;
    if (s) m_len = m_in_stall ? ((m_len < TIMEOUT) ? m_len + 1 : TIMEOUT) : 1;
    else m_len = 0;
    if (clr) begin
      m_events = 0;
      m_cycles = 0;
      m_tout   = 0;
    end else begin
      if (s && !m_in_stall && m_events < CNT_MAX) m_events++;
      if (s && m_cycles < CNT_MAX) m_cycles++;
      if (s && m_len == TIMEOUT && old_len < TIMEOUT) m_tout = 1;
    end
    m_pend     = s ? (m_pend | fhz) : 5'b00000;
    m_in_stall = s;
    #1;
  endtask

  initial begin
    int burst;
    bit rq;
    bit ms;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    miss      = 1'b0;
    mem_req   = 1'b0;
    bubble_hz = '0;
    flush_hz  = '0;
    clr_stats = 1'b0;
    model_reset();
    #2;
    check("rst_events", 32'(miss_events), 32'd0);
    check("rst_cycles", 32'(stall_cycles), 32'd0);
    check("rst_tout", 32'(timeout_err), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single miss of six cycles
    for (int i = 0; i < 6; i++) step(1, 1, 5'b00010, 5'b0, 0);
    step(1, 0, 5'b00010, 5'b0, 0);
    check("sm_events", 32'(miss_events), 32'd1);
    check("sm_cycles", 32'(stall_cycles), 32'd6);

    // Deferred flush: pulse on stall cycle 2, released exactly once afterwards
    step(1, 1, 5'b0, 5'b00000, 0);
    step(1, 1, 5'b0, 5'b11000, 0);
    step(1, 1, 5'b0, 5'b00000, 0);
    step(1, 1, 5'b0, 5'b00000, 0);
    step(0, 0, 5'b0, 5'b00000, 0);
    step(0, 0, 5'b0, 5'b00000, 0);

    // Back-to-back misses with a one-cycle gap carrying a hazard flush
    step(0, 0, 5'b0, 5'b0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 5'b0, 5'b0, 0);
    step(1, 0, 5'b0, 5'b00101, 0);
    for (int i = 0; i < 2; i++) step(1, 1, 5'b0, 5'b0, 0);
    step(0, 0, 5'b0, 5'b0, 0);
    check("b2b_events", 32'(miss_events), 32'd2);
    check("b2b_cycles", 32'(stall_cycles), 32'd5);

    // Watchdog: 12-cycle miss, then clear
    for (int i = 0; i < 12; i++) step(1, 1, 5'b0, 5'b0, 0);
    step(0, 0, 5'b0, 5'b0, 0);
    check("wd_tout", 32'(timeout_err), 32'd1);
    step(0, 0, 5'b0, 5'b0, 1);
    step(0, 0, 5'b0, 5'b0, 0);

    // Stale miss, then counter saturation over 20 stall cycles
    for (int i = 0; i < 3; i++) step(0, 1, 5'b01000, 5'b00010, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 5'b0, 5'b0, 0);
    step(0, 0, 5'b0, 5'b0, 0);
    check("sat_cycles", 32'(stall_cycles), 32'hF);

    // Reset mid-stall with a pending flush
    step(1, 1, 5'b0, 5'b00100, 0);
    step(1, 1, 5'b0, 5'b00000, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mr_events", 32'(miss_events), 32'd0);
    check("mr_cycles", 32'(stall_cycles), 32'd0);
    check("mr_tout", 32'(timeout_err), 32'd0);
    miss = 1'b0;
    #1;
    check("mr_flush", 32'(flush_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 5'b0, 5'b0, 0);

    // Randomised bursts of misses, sparse flushes and occasional clears
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      if (burst == 0 && $urandom_range(3) == 0) burst = $urandom_range(14, 1);
      ms = (burst > 0) || ($urandom_range(15) == 0);
      if (burst > 0) burst--;
      rq = ($urandom_range(7) != 0);
      step(rq, ms, 5'($urandom), ($urandom_range(3) == 0) ? 5'($urandom) : 5'b0,
           ($urandom_range(39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
